// File: rtl/fifo_ctrl112x.sv
// FIFO controller that owns a registered-output dual-port RAM and streams its contents
// through a small prefetch skid buffer. Define FIFO_CTRL_HIWM_EN to get a peak-count register on hiwm.
module fifo_ctrl112x #(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 8,
  parameter int RDLAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [WIDTH-1:0]   in_dat,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [WIDTH-1:0]   out_dat,
  output logic [ADDRBIT-1:0] ram_wa,
  output logic               ram_we,
  output logic [WIDTH-1:0]   ram_di,
  output logic [ADDRBIT-1:0] ram_ra,
  output logic               ram_re,
  input  logic [WIDTH-1:0]   ram_do,
  output logic [ADDRBIT:0]   count,
  output logic [ADDRBIT:0]   hiwm
);

  localparam int BUFN = RDLAT + 1;
  localparam int BCW  = $clog2(BUFN + 1);
  localparam int BIW  = $clog2(BUFN);
  localparam int IFW  = $clog2(RDLAT + 1);
  localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);
  localparam logic [ADDRBIT:0]   FULL = (ADDRBIT + 1)'(DEPTH);

  logic [ADDRBIT-1:0] wptr;
  logic [ADDRBIT-1:0] rptr;
  logic [ADDRBIT:0]   ram_cnt;
  logic [RDLAT-1:0]   rd_sr;
  logic [IFW-1:0]     inflight;
  logic [BCW-1:0]     buf_cnt;
  logic [BCW-1:0]     wr_idx;
  logic [WIDTH-1:0]   bmem  [BUFN];
  logic [WIDTH-1:0]   bnext [BUFN];
  logic               accept;
  logic               push;
  logic               pop;

  assign in_rdy  = ~rst & (count < FULL);
  assign accept  = in_vld & in_rdy;
  assign ram_we  = accept;
  assign ram_wa  = wptr;
  assign ram_di  = in_dat;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RDLAT; i++) inflight = inflight + IFW'(rd_sr[i]);
  end

  // Credit check: never request more than the skid buffer can absorb if the consumer stalls.
  assign ram_re  = (ram_cnt != '0) & ((int'(inflight) + int'(buf_cnt)) < BUFN) & ~flush;
  assign ram_ra  = rptr;
  assign push    = rd_sr[RDLAT-1];

  assign out_vld = (buf_cnt != '0);
  assign out_dat = bmem[0];
  assign pop     = out_vld & out_rdy;
  assign wr_idx  = buf_cnt - BCW'(pop);

  // Head-at-zero shift buffer: a pop moves everything down, a push lands after the survivors.
  always_comb begin
    bnext = bmem;
    if (pop) begin
      for (int i = 0; i < BUFN - 1; i++) bnext[i] = bmem[i + 1];
      bnext[BUFN-1] = '0;
    end
    if (push) bnext[wr_idx[BIW-1:0]] = ram_do;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_sr   <= '0;
      buf_cnt <= '0;
      count   <= '0;
      for (int i = 0; i < BUFN; i++) bmem[i] <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
      rd_sr   <= '0;
      buf_cnt <= '0;
      count   <= '0;
      for (int i = 0; i < BUFN; i++) bmem[i] <= '0;
    end else begin
      if (accept) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (ram_re) rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      rd_sr[0] <= ram_re;
      for (int i = 1; i < RDLAT; i++) rd_sr[i] <= rd_sr[i-1];
      ram_cnt <= ram_cnt + (ADDRBIT + 1)'(accept) - (ADDRBIT + 1)'(ram_re);
      count   <= count + (ADDRBIT + 1)'(accept) - (ADDRBIT + 1)'(pop);
      buf_cnt <= buf_cnt + BCW'(push) - BCW'(pop);
      for (int i = 0; i < BUFN; i++) bmem[i] <= bnext[i];
    end
  end

`ifdef FIFO_CTRL_HIWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                hiwm <= '0;
    else if (flush)         hiwm <= '0;
    else if (count > hiwm)  hiwm <= count;
  end
`else
  assign hiwm = '0;
`endif

endmodule

// File: tb/tb_fifo_ctrl112x.sv
// Directed self-checking bench for fifo_ctrl112x with a behavioural RAM model (DEPTH=5 so pointers wrap).
module tb_fifo_ctrl112x;

  localparam int ADDRBIT = 9;
  localparam int DEPTH   = 5;
  localparam int WIDTH   = 8;
  localparam int RDLAT   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_vld = 1'b0;
  logic               out_rdy = 1'b0;
  logic [WIDTH-1:0]   in_dat = '0;
  logic               in_rdy;
  logic               out_vld;
  logic [WIDTH-1:0]   out_dat;
  logic [ADDRBIT-1:0] ram_wa;
  logic               ram_we;
  logic [WIDTH-1:0]   ram_di;
  logic [ADDRBIT-1:0] ram_ra;
  logic               ram_re;
  logic [WIDTH-1:0]   ram_do;
  logic [ADDRBIT:0]   count;
  logic [ADDRBIT:0]   hiwm;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] sent [$];
  logic [WIDTH-1:0] got  [$];
  int occ = 0;
  int bad_re = 0;
  int bad_ptr = 0;
  int last_ra = -1;
  int last_wa = -1;
  logic saw_wrap_r = 1'b0;
  logic saw_wrap_w = 1'b0;

  fifo_ctrl112x #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH), .RDLAT(RDLAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_do(ram_do),
    .count(count), .hiwm(hiwm)
  );

  always #5 clk = ~clk;

  // RAM model: registered read path RDLAT stages deep, write visible to reads from the next edge.
  logic [WIDTH-1:0] mem  [2**ADDRBIT];
  logic [WIDTH-1:0] rd_q [RDLAT];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) rd_q[0] <= mem[ram_ra];
    for (int k = 1; k < RDLAT; k++) rd_q[k] <= rd_q[k-1];
  end
  assign ram_do = rd_q[RDLAT-1];

  // Mid-cycle monitor: records handshakes and RAM port behaviour.
  always @(negedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      if (in_vld && in_rdy) sent.push_back(in_dat);
      if (out_vld && out_rdy) got.push_back(out_dat);
      if (ram_re) begin
        if (occ == 0) bad_re++;
        if (int'(ram_ra) >= DEPTH) bad_ptr++;
        if (ram_ra == 0 && last_ra == DEPTH - 1) saw_wrap_r = 1'b1;
        last_ra = int'(ram_ra);
      end
      if (ram_we) begin
        if (int'(ram_wa) >= DEPTH) bad_ptr++;
        if (ram_wa == 0 && last_wa == DEPTH - 1) saw_wrap_w = 1'b1;
        last_wa = int'(ram_wa);
      end
      occ = occ + int'(ram_we) - int'(ram_re);
      if (flush) occ = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [WIDTH-1:0] dat, input logic rdy);
    in_vld  = vld;
    in_dat  = dat;
    out_rdy = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic waitEmpty(input string tag);
    int n = 0;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    while (count != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 32'(count), 32'd0);
  endtask

  task automatic compareQueues(input string tag);
    int mism = 0;
    checkOutput({tag, "_size"}, 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      if (got[i] !== sent[i]) mism++;
    checkOutput({tag, "_data"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int exp_hiwm;
    int cnt_bad;
    int cyc;
`ifdef FIFO_CTRL_HIWM_EN
    exp_hiwm = DEPTH;
`else
    exp_hiwm = 0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_vld", 32'(out_vld), 32'd0);
    checkOutput("rst_in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_dat", 32'(out_dat), 32'd0);
    checkOutput("rst_hiwm", 32'(hiwm), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_rdy", 32'(in_rdy), 32'd1);

    // Five words into an empty FIFO: out_vld rises after the third edge following the first accept
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b1);
      checkOutput($sformatf("lat_vld_%0d", i), 32'(out_vld), (i >= 3) ? 32'd1 : 32'd0);
      if (i == 0) checkOutput("first_ram_re", 32'(ram_re), 32'd1);
      if (i == 3) checkOutput("first_dat", 32'(out_dat), 32'h11);
    end
    checkOutput("count_after_5", 32'(count), 32'd4);
    checkOutput("second_dat", 32'(out_dat), 32'h12);
    waitEmpty("drain1");
    compareQueues("order1");
    sent.delete();
    got.delete();

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("fill_rdy_%0d", i), 32'(in_rdy), 32'd1);
      if (i == DEPTH - 1) checkOutput("fill_wa_last", 32'(ram_wa), 32'(DEPTH - 1));
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    end
    checkOutput("full_in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("full_count", 32'(count), 32'(DEPTH));
    checkOutput("full_wa_wrap", 32'(ram_wa), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("stall_count", 32'(count), 32'(DEPTH));
    checkOutput("stall_out_vld", 32'(out_vld), 32'd1);
    checkOutput("stall_out_dat", 32'(out_dat), 32'h20);
    checkOutput("stall_no_re", 32'(ram_re), 32'd0);
    checkOutput("hiwm_full", 32'(hiwm), 32'(exp_hiwm));

    // Full FIFO streaming: count never leaves DEPTH-1..DEPTH
    cnt_bad = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + sent.size()), 1'b1);
      if (int'(count) < DEPTH - 1 || int'(count) > DEPTH) cnt_bad++;
    end
    checkOutput("stream_count_range", 32'(cnt_bad), 32'd0);
    waitEmpty("drain2");
    compareQueues("order2");
    sent.delete();
    got.delete();

    // Random stall pattern over 2000 words
    cyc = 0;
    while (sent.size() < 2000 && cyc < 40000) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'(sent.size()), 1'($urandom_range(0, 1)));
      cyc++;
    end
    checkOutput("rand_sent", 32'(sent.size() >= 2000), 32'd1);
    waitEmpty("drain3");
    compareQueues("order3");
    checkOutput("ra_wrap", 32'(saw_wrap_r), 32'd1);
    checkOutput("wa_wrap", 32'(saw_wrap_w), 32'd1);
    checkOutput("ptr_range", 32'(bad_ptr), 32'd0);
    checkOutput("no_re_on_empty", 32'(bad_re), 32'd0);
    sent.delete();
    got.delete();

    // Flush with two reads in flight: their data must never appear
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    flush = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    checkOutput("flush1_out_vld", 32'(out_vld), 32'd0);
    checkOutput("flush1_count", 32'(count), 32'd0);
    checkOutput("flush1_hiwm", 32'(hiwm), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("flush1_quiet", 32'(out_vld), 32'd0);

    // Flush with a full skid buffer
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    flush = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    flush = 1'b0;
    checkOutput("flush2_out_vld", 32'(out_vld), 32'd0);
    checkOutput("flush2_count", 32'(count), 32'd0);
    checkOutput("flush2_out_dat", 32'(out_dat), 32'd0);
    sent.delete();
    got.delete();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    waitEmpty("drain4");
    checkOutput("after_flush_size", 32'(got.size()), 32'd1);
    checkOutput("after_flush_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'hA5);
    sent.delete();
    got.delete();

    // Reset in the middle of a transfer
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b1);
    checkOutput("pre_rst_out_vld", 32'(out_vld), 32'd1);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_vld", 32'(out_vld), 32'd0);
    checkOutput("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sent.delete();
    got.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h61 + i), 1'b1);
    waitEmpty("drain5");
    checkOutput("post_rst_size", 32'(got.size()), 32'd3);
    compareQueues("order5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
